// File: rtl/vga_if.sv
// vga_if: raster-scan bundle between the timing generator and the screen
// painter / output pins.
//
// Signals (all driven by the master, sampled on clk by the slave):
//   pixel_x[9:0], pixel_y[9:0]  current scan position
//   vid_on                      position is inside the visible window
//   pixel_tick                  one-clk pulse each time the position advances
//   line_start, frame_start     one-clk pulses on the first clk of a new line / frame
//   hsync, vsync                active-low sync, already aligned to the painter pipeline
//
// Flow control: this is a free-running stream with no valid/ready pair. The
// master never stalls and the slave cannot apply backpressure; pixel_tick
// plays the role of "valid" for the position fields.
interface vga_if;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       vid_on;
  logic       pixel_tick;
  logic       line_start;
  logic       frame_start;
  logic       hsync;
  logic       vsync;

  modport master (
    output pixel_x, pixel_y, vid_on, pixel_tick,
    output line_start, frame_start, hsync, vsync
  );

  modport slave (
    input pixel_x, pixel_y, vid_on, pixel_tick,
    input line_start, frame_start, hsync, vsync
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for a VGA-style display, clocked by the
// system clock with an internal pixel-rate enable.
//
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   vga  vga_if.master: pixel_x, pixel_y, vid_on, pixel_tick, line_start,
//        frame_start, hsync, vsync
//
// Parameters: horizontal/vertical display, porch and sync widths; CLK_DIV
// (1..16) clk cycles per pixel; SYNC_DLY (0..7) clk delay on hsync/vsync so
// that sync lines up with the painter's registered colour output.
// H_TOTAL and V_TOTAL must not exceed 1024.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4,
  parameter int SYNC_DLY  = 2
) (
  input logic   clk,
  input logic   rst,
  vga_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

  // Sync window bounds are 11 bits so an end bound of exactly 1024 still
  // compares correctly against the 10-bit counters.
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FP + V_SYNC);

  logic [3:0] div;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       tick;
  logic       hsync_raw;
  logic       vsync_raw;

  // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so tick is always high.
  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= 4'd0;
    end else if (tick) begin
      div <= 4'd0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // Counters park on the last blanking position in reset so the first tick
  // after release lands exactly on (0,0) and raises frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 10'd0;
        if (v_cnt == V_LAST) begin
          v_cnt <= 10'd0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    hsync_raw = 1'b1;
    vsync_raw = 1'b1;
    if (({1'b0, h_cnt} >= HS_START) && ({1'b0, h_cnt} < HS_END)) begin
      hsync_raw = 1'b0;
    end
    if (({1'b0, v_cnt} >= VS_START) && ({1'b0, v_cnt} < VS_END)) begin
      vsync_raw = 1'b0;
    end
  end

  // Sync delay runs every clk (not on pixel_tick) because it mirrors the
  // painter's clk-rate pipeline, not a pixel-rate one.
  generate
    if (SYNC_DLY == 0) begin : g_no_dly
      assign vga.hsync = hsync_raw;
      assign vga.vsync = vsync_raw;
    end else begin : g_dly
      logic [SYNC_DLY-1:0] hs_pipe;
      logic [SYNC_DLY-1:0] vs_pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe <= (hs_pipe << 1) | SYNC_DLY'(hsync_raw);
          vs_pipe <= (vs_pipe << 1) | SYNC_DLY'(vsync_raw);
        end
      end

      assign vga.hsync = hs_pipe[SYNC_DLY-1];
      assign vga.vsync = vs_pipe[SYNC_DLY-1];
    end
  endgenerate

  assign vga.pixel_x     = h_cnt;
  assign vga.pixel_y     = v_cnt;
  assign vga.pixel_tick  = tick;
  assign vga.vid_on      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign vga.line_start  = (h_cnt == 10'd0) && (div == 4'd0);
  assign vga.frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0) && (div == 4'd0);

endmodule
